// File: rtl/lut_rom_arb.sv
// lut_rom_arb: round-robin arbiter giving up to NUM_REQ requesters access to
// a dual-port, 1-cycle-latency LUT ROM. Two grants per cycle (port A, port B),
// responses return one cycle after the grant and are routed back by a tag.
// Optional build macro: LUT_ROM_ARB_STATS_EN adds a saturating stall counter.
module lut_rom_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_W-1:0]             rom_addr_a,
    output logic [ADDR_W-1:0]             rom_addr_b,
    input  logic [DATA_WIDTH-1:0]         rom_dout_a,
    input  logic [DATA_WIDTH-1:0]         rom_dout_b,
    output logic                          busy,
    output logic [15:0]                   stall_cnt
);

    localparam int              PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]  NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             tag_a_vld_q, tag_b_vld_q;
    logic [PTR_W-1:0] tag_a_idx_q, tag_b_idx_q;

    logic             grant_en;
    logic             gnt_a_vld, gnt_b_vld;
    logic [PTR_W-1:0] gnt_a_idx, gnt_b_idx;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W:0]   scan_sum;
    logic [PTR_W:0]   next_sum;

    // Grants are suppressed while disabled or held in reset.
    assign grant_en = en && !rst;

    // Scan from rr_ptr upward (wrapping); first valid takes port A, second port B.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch can be inferred.
        gnt_a_vld = 1'b0;
        gnt_a_idx = '0;
        gnt_b_vld = 1'b0;
        gnt_b_idx = '0;
        scan_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= NUM_REQ_W) begin
                scan_sum = scan_sum - NUM_REQ_W;
            end
            if (grant_en && req_valid[scan_sum[PTR_W-1:0]]) begin
                if (!gnt_a_vld) begin
                    gnt_a_vld = 1'b1;
                    gnt_a_idx = scan_sum[PTR_W-1:0];
                end else if (!gnt_b_vld) begin
                    gnt_b_vld = 1'b1;
                    gnt_b_idx = scan_sum[PTR_W-1:0];
                end
            end
        end
    end

    // Pointer moves just past the last granted requester; holds when idle.
    always_comb begin
        last_idx = gnt_b_vld ? gnt_b_idx : gnt_a_idx;
        next_sum = {1'b0, last_idx} + (PTR_W+1)'(1);
        if (next_sum == NUM_REQ_W) begin
            next_sum = '0;
        end
        rr_ptr_d = gnt_a_vld ? next_sum[PTR_W-1:0] : rr_ptr_q;
    end

    // Decode grants into per-requester ready and ROM port addresses (0 when unused).
    always_comb begin
        req_ready  = '0;
        rom_addr_a = '0;
        rom_addr_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_a_vld && gnt_a_idx == PTR_W'(i)) begin
                req_ready[i] = 1'b1;
                rom_addr_a   = req_addr[i*ADDR_W +: ADDR_W];
            end
            if (gnt_b_vld && gnt_b_idx == PTR_W'(i)) begin
                req_ready[i] = 1'b1;
                rom_addr_b   = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Round-robin pointer and per-port response tags.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            rr_ptr_q    <= '0;
            tag_a_vld_q <= 1'b0;
            tag_a_idx_q <= '0;
            tag_b_vld_q <= 1'b0;
            tag_b_idx_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tag_a_vld_q <= gnt_a_vld;
            tag_a_idx_q <= gnt_a_idx;
            tag_b_vld_q <= gnt_b_vld;
            tag_b_idx_q <= gnt_b_idx;
        end
    end

    // Route ROM read data back to the tagged requesters; zero elsewhere.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_a_vld_q && tag_a_idx_q == PTR_W'(i)) begin
                rsp_valid[i]                         = 1'b1;
                rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rom_dout_a;
            end
            if (tag_b_vld_q && tag_b_idx_q == PTR_W'(i)) begin
                rsp_valid[i]                         = 1'b1;
                rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = rom_dout_b;
            end
        end
    end

    assign busy = tag_a_vld_q || tag_b_vld_q;

`ifdef LUT_ROM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic        stall_hit;

    assign stall_hit = en && |(req_valid & ~req_ready);

    // Count enabled cycles where some request was left waiting; saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_hit && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
